// File: rtl/instr_mem.sv
// instr_mem: MEM pipeline stage. Captures EX results, performs the data-memory
// access with alignment and timeout checks, and presents the WB results.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module instr_mem #(
    parameter int DATA_WIDTH  = `DATA_WIDTH,
    parameter int ADDR_WIDTH  = `ADDR_WIDTH,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clk_87,
    input  logic                  rst_87,
    // EX stage: valid_in_87 is accepted only while stall_out_87 is low;
    // upstream holds its inputs while stall_out_87 is high.
    input  logic                  valid_in_87,
    input  logic                  zero_in_87,
    input  logic [DATA_WIDTH-1:0] alu_out_in_87,
    input  logic [ADDR_WIDTH-1:0] pc_brnch_in_87,
    input  logic [DATA_WIDTH-1:0] rval_b_in_87,
    input  logic                  mem_read_87,
    input  logic                  mem_write_87,
    input  logic                  branch_87,
    input  logic                  reg_write_87,
    input  logic                  mem_to_reg_87,
    input  logic [4:0]            wr_reg_87,
    // Data memory: dmem_req_87 and its payload stay stable until dmem_ack_87.
    output logic                  dmem_req_87,
    output logic                  dmem_we_87,
    output logic [ADDR_WIDTH-1:0] dmem_addr_87,
    output logic [DATA_WIDTH-1:0] dmem_wdata_87,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_87,
    input  logic                  dmem_ack_87,
    // WB stage
    output logic                  valid_out_87,
    output logic [DATA_WIDTH-1:0] rd_data_out_87,
    output logic [DATA_WIDTH-1:0] alu_out_out_87,
    output logic [4:0]            wr_reg_out_87,
    output logic                  reg_write_out_87,
    output logic                  mem_to_reg_out_87,
    // Branch resolution, upstream stall and sticky errors
    output logic                  pc_src_out_87,
    output logic [ADDR_WIDTH-1:0] pc_brnch_out_87,
    output logic                  stall_out_87,
    output logic                  err_align_87,
    output logic                  err_timeout_87
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [DATA_WIDTH-1:0] alu_q, alu_d;
    logic [ADDR_WIDTH-1:0] pc_brnch_q, pc_brnch_d;
    logic [DATA_WIDTH-1:0] rval_b_q, rval_b_d;
    logic                  zero_q, zero_d;
    logic                  branch_q, branch_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic                  reg_write_q, reg_write_d;
    logic                  mem_to_reg_q, mem_to_reg_d;
    logic [4:0]            wr_reg_q, wr_reg_d;
    logic                  err_align_q, err_align_d;
    logic                  err_timeout_q, err_timeout_d;

    logic mem_access;
    logic misaligned;

    assign mem_access = mem_read_87 | mem_write_87;
    assign misaligned = mem_access & (alu_out_in_87[1:0] != 2'b00);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        valid_d       = 1'b0;
        rd_data_d     = rd_data_q;
        alu_d         = alu_q;
        pc_brnch_d    = pc_brnch_q;
        rval_b_d      = rval_b_q;
        zero_d        = zero_q;
        branch_d      = branch_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        reg_write_d   = reg_write_q;
        mem_to_reg_d  = mem_to_reg_q;
        wr_reg_d      = wr_reg_q;
        err_align_d   = err_align_q;
        err_timeout_d = err_timeout_q;

        case (state_q)
            S_IDLE: begin
                if (valid_in_87) begin
                    alu_d        = alu_out_in_87;
                    pc_brnch_d   = pc_brnch_in_87;
                    rval_b_d     = rval_b_in_87;
                    zero_d       = zero_in_87;
                    branch_d     = branch_87;
                    mem_read_d   = mem_read_87;
                    mem_write_d  = mem_write_87;
                    mem_to_reg_d = mem_to_reg_87;
                    wr_reg_d     = wr_reg_87;
                    reg_write_d  = reg_write_87 & ~misaligned;
                    rd_data_d    = '0;
                    cnt_d        = '0;
                    if (mem_access && !misaligned) begin
                        state_d = S_WAIT;
                    end else begin
                        // Misaligned accesses never reach memory; they retire
                        // like an ALU op but without a register write.
                        valid_d = 1'b1;
                        if (misaligned) begin
                            err_align_d = 1'b1;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (dmem_ack_87) begin
                    state_d = S_IDLE;
                    valid_d = 1'b1;
                    if (mem_read_q) begin
                        rd_data_d = dmem_rdata_87;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = S_IDLE;
                    valid_d       = 1'b1;
                    rd_data_d     = '0;
                    reg_write_d   = 1'b0;
                    err_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_87 or posedge rst_87) begin
        if (rst_87) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            valid_q       <= 1'b0;
            rd_data_q     <= '0;
            alu_q         <= '0;
            pc_brnch_q    <= '0;
            rval_b_q      <= '0;
            zero_q        <= 1'b0;
            branch_q      <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_to_reg_q  <= 1'b0;
            wr_reg_q      <= '0;
            err_align_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            valid_q       <= valid_d;
            rd_data_q     <= rd_data_d;
            alu_q         <= alu_d;
            pc_brnch_q    <= pc_brnch_d;
            rval_b_q      <= rval_b_d;
            zero_q        <= zero_d;
            branch_q      <= branch_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            reg_write_q   <= reg_write_d;
            mem_to_reg_q  <= mem_to_reg_d;
            wr_reg_q      <= wr_reg_d;
            err_align_q   <= err_align_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign stall_out_87  = (state_q == S_WAIT);
    assign dmem_req_87   = stall_out_87;
    assign dmem_we_87    = stall_out_87 & mem_write_q;
    assign dmem_addr_87  = stall_out_87 ? ADDR_WIDTH'(alu_q) : '0;
    assign dmem_wdata_87 = stall_out_87 ? rval_b_q : '0;

    assign valid_out_87      = valid_q;
    assign rd_data_out_87    = rd_data_q;
    assign alu_out_out_87    = alu_q;
    assign wr_reg_out_87     = wr_reg_q;
    assign reg_write_out_87  = valid_q & reg_write_q;
    assign mem_to_reg_out_87 = mem_to_reg_q;

    assign pc_src_out_87   = valid_q & branch_q & zero_q;
    assign pc_brnch_out_87 = valid_q ? pc_brnch_q : '0;

    assign err_align_87   = err_align_q;
    assign err_timeout_87 = err_timeout_q;

endmodule

// File: doc/instr_mem.md
INSTR_MEM -- requirements
Module: instr_mem

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default `DATA_WIDTH (32), data path width.
REQ-002 SHALL have parameter ADDR_WIDTH, default `ADDR_WIDTH (32), address width.
REQ-003 SHALL have parameter MEM_TIMEOUT, default 15, maximum cycles to wait for dmem_ack_87.
REQ-004 SHALL have port clk_87, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_87, input, 1, reset, asynchronous and active-high.
REQ-006 SHALL have port valid_in_87, input, 1, EX stage presents an instruction this cycle.
REQ-007 SHALL have ports zero_in_87 (1), alu_out_in_87 (DATA_WIDTH), pc_brnch_in_87 (ADDR_WIDTH) and rval_b_in_87 (DATA_WIDTH), all inputs, carrying the EX results and the store data.
REQ-008 SHALL have control inputs mem_read_87, mem_write_87, branch_87, reg_write_87 and mem_to_reg_87 (1 each), plus wr_reg_87 (5), the destination register.
REQ-009 SHALL have data-memory ports: dmem_req_87 out 1, dmem_we_87 out 1, dmem_addr_87 out ADDR_WIDTH, dmem_wdata_87 out DATA_WIDTH, dmem_rdata_87 in DATA_WIDTH, dmem_ack_87 in 1.
REQ-010 SHALL have WB outputs valid_out_87 (1), rd_data_out_87 (DATA_WIDTH), alu_out_out_87 (DATA_WIDTH), wr_reg_out_87 (5), reg_write_out_87 (1) and mem_to_reg_out_87 (1).
REQ-011 SHALL have branch outputs pc_src_out_87 (1) and pc_brnch_out_87 (ADDR_WIDTH), plus stall_out_87 (1) to upstream, err_align_87 (1, sticky) and err_timeout_87 (1, sticky).

Function
REQ-012 SHALL implement the FSM states IDLE and WAIT; stall_out_87 = (state==WAIT), decoded from the state register only.
REQ-013 SHALL, in IDLE with valid_in_87=1, capture all EX inputs and controls into internal registers at the clock edge.
REQ-014 SHALL treat an instruction as a memory op when mem_read_87 or mem_write_87 is set and alu_out_in_87[1:0]==0.
REQ-015 SHALL complete a non-memory op one cycle after capture: valid_out_87=1 for exactly one cycle, with the captured values on all WB outputs.
REQ-016 SHALL move a memory op to WAIT at the capture edge; while in WAIT, dmem_req_87=1, dmem_addr_87=captured ALU result, dmem_we_87=captured mem_write, dmem_wdata_87=captured rval_b.
REQ-017 SHALL, in WAIT with dmem_ack_87=1 at an edge, latch dmem_rdata_87 into rd_data_out_87 (loads only), return to IDLE and pulse valid_out_87 on the next cycle; minimum load/store latency is therefore 2 cycles from capture.
REQ-018 SHALL hold dmem_req_87 and every dmem output stable until ack; dmem_req_87=0 in IDLE.
REQ-019 SHALL ignore valid_in_87 while in WAIT; upstream holds its inputs while stall_out_87=1.
REQ-020 SHALL ignore dmem_ack_87 while in IDLE.
REQ-021 SHALL count WAIT cycles; if the count reaches MEM_TIMEOUT without ack, it SHALL set err_timeout_87, return to IDLE, complete with rd_data_out_87=0 and reg_write_out_87=0; ack arriving on that same edge takes priority (normal completion).
REQ-022 SHALL, for a misaligned mem op, not issue a request, set err_align_87, and complete as a non-memory op with reg_write_out_87=0.
REQ-023 SHALL drive pc_src_out_87 = captured branch AND captured zero, and pc_brnch_out_87 = captured pc_brnch, both qualified with valid_out_87 (pc_src_out_87=0 when valid_out_87=0).
REQ-024 SHALL clear error flags only on reset.

Reset
REQ-025 SHALL, when rst_87=1, immediately (asynchronously) force state=IDLE, the counter to 0, and valid_out_87, dmem_req_87, dmem_we_87, pc_src_out_87, stall_out_87, reg_write_out_87, err_align_87 and err_timeout_87 to 0; all data outputs SHALL be 0.
REQ-026 SHALL abandon an in-flight WAIT on reset without completion; a late ack after reset is ignored.

Verification
REQ-027 SHALL pass these scenarios:
- ADD, alu_out=0x10, reg_write=1, wr_reg=5 -> one cycle later valid_out=1, alu_out_out=0x10, wr_reg_out=5, stall_out=0.
- LW, addr 0x40, ack 3 cycles after req, rdata=0xDEADBEEF -> stall_out high for 3 cycles, then valid_out=1, rd_data_out=0xDEADBEEF, mem_to_reg_out=1.
- SW, addr 0x44, rval_b=0x1234 -> dmem_we=1, wdata=0x1234 until ack; reg_write_out=0 at completion.
- BEQ, zero=1, pc_brnch=0x100 -> pc_src_out=1 and pc_brnch_out=0x100 for exactly one cycle; with zero=0 -> pc_src_out=0.
- LW, addr 0x42 -> no dmem_req, err_align_87=1, valid_out=1 with reg_write_out=0; LW with no ack -> err_timeout_87=1 after 15 WAIT cycles.
- rst_87 asserted mid-WAIT -> dmem_req_87 low in the same cycle, state IDLE, no valid_out pulse.
